// File: rtl/sigma_pkg.sv
// Shared constants, FSM state type and the reciprocal table for the sigma averaging stage.
// The reciprocal is used to turn a sum into a mean without a divider.
package sigma_pkg;

    localparam int PIX_W   = 8;
    localparam int DIFF_W  = 9;
    localparam int SUM_W   = 12;
    localparam int RECIP_W = 13;
    localparam int FRAC    = 12;

    typedef enum logic [1:0] {
        S_ACC,
        S_MUL,
        S_OUT
    } state_t;

    // Unsigned Q1.12 value of round(4096/k), for sample counts k = 1..9.
    function automatic logic [RECIP_W-1:0] recip(input logic [3:0] k);
        logic [RECIP_W-1:0] r;
        case (k)
            4'd1:    r = 13'd4096;
            4'd2:    r = 13'd2048;
            4'd3:    r = 13'd1365;
            4'd4:    r = 13'd1024;
            4'd5:    r = 13'd819;
            4'd6:    r = 13'd683;
            4'd7:    r = 13'd585;
            4'd8:    r = 13'd512;
            4'd9:    r = 13'd455;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sigma_diff_accum_abs_thr_cmp.sv
// Keep flag for one neighbour: |diff| <= thr.
// Combinational, zero latency. No flow control.
// -256 is kept out naturally: its 9-bit magnitude is 256, which no 8-bit threshold reaches.
module abs_thr_cmp
    import sigma_pkg::*;
(
    input  logic [DIFF_W-1:0] diff,
    input  logic [PIX_W-1:0]  thr,
    output logic              keep
);

    logic [DIFF_W-1:0] mag;

    always_comb begin
        mag  = diff[DIFF_W-1] ? (~diff + 1'b1) : diff;
        keep = (mag <= {1'b0, thr});
    end

endmodule

// File: rtl/sigma_diff_accum.sv
// Sigma filter: centre + mean of neighbour diffs within threshold (centre counts as a sample).
// Latency: last beat accepted in cycle t -> out_valid in cycle t+2. One group in flight.
// Backpressure: in_ready drops from the last beat until the result is taken; outputs hold while out_ready=0.
module sigma_diff_accum #(
    parameter int MAX_NEIGH = 8,
    parameter int RECIP_W   = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_diff,
    input  logic [7:0] in_center,
    input  logic [7:0] in_thr,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pixel,
    output logic [3:0] out_count,
    output logic       protocol_err
);
    import sigma_pkg::*;

    localparam int PROD_W = SUM_W + RECIP_W + 1;

    state_t state, state_nxt;

    logic signed [SUM_W-1:0]  sum, sum_base, sum_nxt, diff_ext;
    logic [3:0]               cnt, cnt_base, cnt_nxt;
    logic [3:0]               beat_cnt;
    logic [PIX_W-1:0]         centre_r, thr_r, thr_eff;
    logic signed [PROD_W-1:0] prod, prod_nxt, q, pix_full;
    logic [RECIP_W-1:0]       recip_k;
    logic                     first_beat, keep, accept, at_max, close_grp;

    assign first_beat = (beat_cnt == 4'd0);
    // Centre and threshold only matter on the first beat; later beats use the latched copy.
    assign thr_eff    = first_beat ? in_thr : thr_r;

    abs_thr_cmp u_abs_thr_cmp (
        .diff (in_diff),
        .thr  (thr_eff),
        .keep (keep)
    );

    always_comb begin
        accept    = in_valid && (state == S_ACC);
        at_max    = (beat_cnt == 4'(MAX_NEIGH - 1));
        close_grp = accept && (in_last || at_max);

        diff_ext  = {{(SUM_W-DIFF_W){in_diff[DIFF_W-1]}}, in_diff};
        sum_base  = first_beat ? '0 : sum;
        cnt_base  = first_beat ? 4'd0 : cnt;
        sum_nxt   = keep ? (sum_base + diff_ext) : sum_base;
        cnt_nxt   = keep ? (cnt_base + 4'd1) : cnt_base;

        recip_k   = recip(cnt + 4'd1);
        prod_nxt  = $signed(sum) * $signed({1'b0, recip_k});
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_ACC: begin
                in_ready = 1'b1;
                if (close_grp)
                    state_nxt = S_MUL;
            end
            S_MUL: state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_ACC;
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_ACC;
            sum          <= '0;
            cnt          <= '0;
            beat_cnt     <= '0;
            centre_r     <= '0;
            thr_r        <= '0;
            prod         <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sum      <= sum_nxt;
                cnt      <= cnt_nxt;
                beat_cnt <= beat_cnt + 4'd1;
                if (first_beat) begin
                    centre_r <= in_center;
                    thr_r    <= in_thr;
                end
                if (at_max && !in_last)
                    protocol_err <= 1'b1;
            end
            if (state == S_MUL)
                prod <= prod_nxt;
            if (state == S_OUT && out_ready)
                beat_cnt <= '0;
        end
    end

    // Round half up, then saturate to the pixel range.
    always_comb begin
        q        = (prod + PROD_W'(2048)) >>> FRAC;
        pix_full = $signed({{(PROD_W-PIX_W){1'b0}}, centre_r}) + q;
        if (pix_full < 0)
            out_pixel = 8'd0;
        else if (pix_full > PROD_W'(255))
            out_pixel = 8'd255;
        else
            out_pixel = pix_full[PIX_W-1:0];
        out_count = cnt;
    end

endmodule

// File: tb/tb_sigma_diff_accum.sv
module tb_sigma_diff_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_diff;
    logic [7:0] in_center;
    logic [7:0] in_thr;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic [3:0] out_count;
    logic       protocol_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] diffs [8];

    always #5 clk = ~clk;

    sigma_diff_accum dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_diff      (in_diff),
        .in_center    (in_center),
        .in_thr       (in_thr),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_count    (out_count),
        .protocol_err (protocol_err)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-first beats carry junk centre/threshold so that re-latching would be visible.
    task automatic run_group(input logic [7:0] c, input logic [7:0] t, input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_diff   = diffs[i];
            in_center = (i == 0) ? c : ~c;
            in_thr    = (i == 0) ? t : 8'hFF;
            in_last   = use_last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_group(input string tag, input int exp_pix, input int exp_cnt);
        check_eq({tag, "_valid_t1"}, int'(out_valid), 0);
        tick();
        check_eq({tag, "_valid_t2"}, int'(out_valid), 1);
        check_eq({tag, "_pixel"}, int'(out_pixel), exp_pix);
        check_eq({tag, "_count"}, int'(out_count), exp_cnt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, int'(out_valid), 0);
        check_eq({tag, "_ready_back"}, int'(in_ready), 1);
    endtask

    task automatic fill(input logic [8:0] d);
        for (int i = 0; i < 8; i++) diffs[i] = d;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_diff = '0; in_center = '0;
        in_thr = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_pixel", int'(out_pixel), 0);
        check_eq("rst_out_count", int'(out_count), 0);
        check_eq("rst_perr", int'(protocol_err), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);

        // 1: all kept, sum=40, cnt=8 -> 40*455 -> q=4
        fill(9'd5);
        run_group(8'd100, 8'd10, 8, 1'b1);
        finish_group("t1", 104, 8);

        // 2: kept {+2,-2,+3,0}, sum=3 -> 3*819 -> q=1
        diffs[0] = 9'd2;   diffs[1] = -9'sd2; diffs[2] = 9'd4; diffs[3] = -9'sd4;
        diffs[4] = 9'd3;   diffs[5] = 9'd0;   diffs[6] = 9'd9; diffs[7] = -9'sd9;
        run_group(8'd100, 8'd3, 8, 1'b1);
        finish_group("t2", 101, 4);

        // 3: nothing kept -> centre unchanged; -256 never kept even at thr=255
        fill(9'd7);
        run_group(8'd200, 8'd0, 8, 1'b1);
        finish_group("t3a", 200, 0);
        diffs[0] = 9'h100;
        run_group(8'd50, 8'd255, 1, 1'b1);
        finish_group("t3b", 50, 0);

        // 4: sum=-16 -> -7280+2048 >>> 12 = -2 -> 0
        fill(-9'sd2);
        run_group(8'd2, 8'd5, 8, 1'b1);
        finish_group("t4", 0, 8);

        // 5: backpressure, single beat +5: 5*2048 -> q=3 -> 103
        diffs[0] = 9'd5;
        run_group(8'd100, 8'd10, 1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_hold_valid", int'(out_valid), 1);
            check_eq("t5_hold_pixel", int'(out_pixel), 103);
            check_eq("t5_hold_count", int'(out_count), 1);
            check_eq("t5_hold_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t5_valid_drop", int'(out_valid), 0);
        check_eq("t5_ready_back", int'(in_ready), 1);

        // 6a: 3 beats, sum=9 cnt=3 -> 9*1024 -> q=2 -> 12
        diffs[0] = 9'd6; diffs[1] = 9'd6; diffs[2] = -9'sd3;
        run_group(8'd10, 8'd20, 3, 1'b1);
        check_eq("t6a_perr", int'(protocol_err), 0);
        finish_group("t6a", 12, 3);

        // 6b: truncation, sum=320 cnt=8 -> q=36, 250+36 clamps to 255
        fill(9'd40);
        run_group(8'd250, 8'd50, 8, 1'b0);
        check_eq("t6b_perr", int'(protocol_err), 1);
        finish_group("t6b", 255, 8);
        fill(9'd5);
        run_group(8'd100, 8'd10, 8, 1'b1);
        finish_group("t6b_next", 104, 8);
        check_eq("t6b_sticky", int'(protocol_err), 1);

        // 6c: reset mid-group, then single beat -4: -8192+2048 >>> 12 = -2 -> 58
        fill(9'd100);
        run_group(8'd0, 8'd200, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6c_no_out", int'(out_valid), 0);
        check_eq("t6c_perr_clr", int'(protocol_err), 0);
        check_eq("t6c_in_ready", int'(in_ready), 1);
        diffs[0] = -9'sd4;
        run_group(8'd60, 8'd10, 1, 1'b1);
        finish_group("t6c", 58, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
